// File: rtl/fma_operand_unpack_pkg.sv
// ---------------------------------------------------------------------------
// fma_pkg
// Shared definitions for the FMA operand unpacker: default binary format
// (half precision), the per-operand class-flag struct and helper functions
// that derive the exponent bias and packed operand width from NE/NF.
// ---------------------------------------------------------------------------
package fma_pkg;

    localparam int DEF_NE = 5;
    localparam int DEF_NF = 10;

    // At most one flag is set; all clear means a normal number.
    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
        logic sub;
    } fp_class_t;

    function automatic int fp_bias(input int ne);
        return (1 << (ne - 1)) - 1;
    endfunction

    function automatic int fp_width(input int ne, input int nf);
        return 1 + ne + nf;
    endfunction

endpackage

// File: rtl/fma_operand_unpack_if.sv
// ---------------------------------------------------------------------------
// fma_operand_unpack_if
// Bundles the unpacker's input beat (x/y/z plus op controls, valid/ready),
// the unpacked output beat (sign/exp/sig/class per operand, invalid,
// valid/ready) and the sticky-invalid flag with its clear.
//   slave  : seen by the unpacker
//   master : seen by the operand source / consumer
// ---------------------------------------------------------------------------
interface fma_operand_unpack_if
    import fma_pkg::*;
#(
    parameter int NE = DEF_NE,
    parameter int NF = DEF_NF
);
    localparam int N = fp_width(NE, NF);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [N-1:0]  z;
    logic          mul;
    logic          add;
    logic          negp;
    logic          negz;

    logic          out_valid;
    logic          out_ready;
    logic          x_sign, y_sign, z_sign;
    logic [NE+1:0] x_exp, y_exp, z_exp;
    logic [NF:0]   x_sig, y_sig, z_sig;
    logic          x_zero, y_zero, z_zero;
    logic          x_inf, y_inf, z_inf;
    logic          x_qnan, y_qnan, z_qnan;
    logic          x_snan, y_snan, z_snan;
    logic          x_sub, y_sub, z_sub;
    logic          invalid;

    logic          flag_clr;
    logic          invalid_sticky;

    modport slave (
        input  in_valid, x, y, z, mul, add, negp, negz, out_ready, flag_clr,
        output in_ready, out_valid,
               x_sign, y_sign, z_sign, x_exp, y_exp, z_exp,
               x_sig, y_sig, z_sig, x_zero, y_zero, z_zero,
               x_inf, y_inf, z_inf, x_qnan, y_qnan, z_qnan,
               x_snan, y_snan, z_snan, x_sub, y_sub, z_sub,
               invalid, invalid_sticky
    );

    modport master (
        output in_valid, x, y, z, mul, add, negp, negz, out_ready, flag_clr,
        input  in_ready, out_valid,
               x_sign, y_sign, z_sign, x_exp, y_exp, z_exp,
               x_sig, y_sig, z_sig, x_zero, y_zero, z_zero,
               x_inf, y_inf, z_inf, x_qnan, y_qnan, z_qnan,
               x_snan, y_snan, z_snan, x_sub, y_sub, z_sub,
               invalid, invalid_sticky
    );

endinterface

// File: rtl/fma_operand_unpack_fp_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc
// Combinational count-leading-zeros over a W-bit vector.
//   in_vec : vector to scan (MSB first)
//   count  : number of leading zeros, W when in_vec is all zero
// ---------------------------------------------------------------------------
module fp_lzc #(
    parameter int W  = 10,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  in_vec,
    output logic [CW-1:0] count
);

    // The highest set bit is visited last and therefore wins.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (in_vec[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fma_operand_unpack.sv
// ---------------------------------------------------------------------------
// fma_operand_unpack
// Two-stage valid/ready pipeline that unpacks the three FMA operands.
// Stage 1 applies the mul/add/negp/negz substitutions and classifies each
// operand; stage 2 normalises subnormals, unbiases the exponent and
// computes the IEEE invalid condition. A sticky invalid flag accumulates
// over accepted output beats.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : slave side of fma_operand_unpack_if
// ---------------------------------------------------------------------------
module fma_operand_unpack
    import fma_pkg::*;
#(
    parameter int NE = DEF_NE,
    parameter int NF = DEF_NF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fma_operand_unpack_if.slave   bus
);

    localparam int B  = fp_bias(NE);
    localparam int N  = fp_width(NE, NF);
    localparam int CW = $clog2(NF + 1);

    localparam logic [NE-1:0] BIAS_E      = NE'(B);
    localparam logic [NE-1:0] E_ONES      = '1;
    localparam logic [NE+1:0] BIAS_X      = (NE + 2)'(B);
    localparam logic [NE+1:0] ONE_MINUS_B = (NE + 2)'(1 - B);

    logic [N-1:0]  opnd      [3];
    fp_class_t     cls_in    [3];

    logic          s1_valid_q, s1_valid_d;
    logic          s1_sign_q [3], s1_sign_d [3];
    logic [NE-1:0] s1_expf_q [3], s1_expf_d [3];
    logic [NF-1:0] s1_frac_q [3], s1_frac_d [3];
    fp_class_t     s1_cls_q  [3], s1_cls_d  [3];

    logic [CW-1:0] lz        [3];
    logic [NE+1:0] unp_exp   [3];
    logic [NF:0]   unp_sig   [3];
    logic          invalid_calc;

    logic          s2_valid_q, s2_valid_d;
    logic          s2_sign_q [3], s2_sign_d [3];
    logic [NE+1:0] s2_exp_q  [3], s2_exp_d  [3];
    logic [NF:0]   s2_sig_q  [3], s2_sig_d  [3];
    fp_class_t     s2_cls_q  [3], s2_cls_d  [3];
    logic          s2_invalid_q, s2_invalid_d;
    logic          sticky_q, sticky_d;

    logic          s2_ready;
    logic          s1_ready;

    assign s2_ready     = ~s2_valid_q | bus.out_ready;
    assign s1_ready     = ~s1_valid_q | s2_ready;
    assign bus.in_ready = s1_ready;

    // Substitute the operands, then classify on the substituted encoding.
    // Without mul, y becomes +1.0 so the product degenerates to x.
    always_comb begin
        opnd[0] = bus.x;
        opnd[1] = bus.mul ? bus.y : {1'b0, BIAS_E, {NF{1'b0}}};
        opnd[1][N-1] = opnd[1][N-1] ^ bus.negp;
        opnd[2] = bus.add ? bus.z : '0;
        opnd[2][N-1] = opnd[2][N-1] ^ bus.negz;
        for (int i = 0; i < 3; i++) begin
            cls_in[i].zero = (opnd[i][N-2:NF] == '0) && (opnd[i][NF-1:0] == '0);
            cls_in[i].sub  = (opnd[i][N-2:NF] == '0) && (opnd[i][NF-1:0] != '0);
            cls_in[i].inf  = (opnd[i][N-2:NF] == E_ONES) && (opnd[i][NF-1:0] == '0);
            cls_in[i].qnan = (opnd[i][N-2:NF] == E_ONES) && opnd[i][NF-1];
            cls_in[i].snan = (opnd[i][N-2:NF] == E_ONES) && (opnd[i][NF-1:0] != '0)
                             && !opnd[i][NF-1];
        end
    end

    // Stage 1 takes a new beat whenever it is empty or draining into stage 2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        for (int i = 0; i < 3; i++) begin
            s1_sign_d[i] = s1_sign_q[i];
            s1_expf_d[i] = s1_expf_q[i];
            s1_frac_d[i] = s1_frac_q[i];
            s1_cls_d[i]  = s1_cls_q[i];
        end
        if (s1_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < 3; i++) begin
                    s1_sign_d[i] = opnd[i][N-1];
                    s1_expf_d[i] = opnd[i][N-2:NF];
                    s1_frac_d[i] = opnd[i][NF-1:0];
                    s1_cls_d[i]  = cls_in[i];
                end
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lzc
        fp_lzc #(.W(NF), .CW(CW)) u_lzc (
            .in_vec (s1_frac_q[g]),
            .count  (lz[g])
        );
    end

    // Subnormals shift left by lzc+1 so the leading one lands on bit NF;
    // the exponent drops by the same amount below the minimum normal.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (s1_cls_q[i].sub) begin
                unp_exp[i] = ONE_MINUS_B - ({{(NE + 2 - CW){1'b0}}, lz[i]} + (NE + 2)'(1));
                unp_sig[i] = ({1'b0, s1_frac_q[i]} << lz[i]) << 1;
            end else if (s1_cls_q[i].zero) begin
                unp_exp[i] = '0;
                unp_sig[i] = '0;
            end else begin
                unp_exp[i] = {2'b00, s1_expf_q[i]} - BIAS_X;
                unp_sig[i] = {1'b1, s1_frac_q[i]};
            end
        end
    end

    // Invalid: any signalling NaN, inf*0, or inf-inf between product and z.
    // The inf-inf term only applies when no operand is a NaN.
    always_comb begin
        logic any_snan;
        logic any_nan;
        logic prod_inf;
        any_snan = s1_cls_q[0].snan | s1_cls_q[1].snan | s1_cls_q[2].snan;
        any_nan  = any_snan | s1_cls_q[0].qnan | s1_cls_q[1].qnan | s1_cls_q[2].qnan;
        prod_inf = s1_cls_q[0].inf | s1_cls_q[1].inf;
        invalid_calc = any_snan
                     | (s1_cls_q[0].inf & s1_cls_q[1].zero)
                     | (s1_cls_q[0].zero & s1_cls_q[1].inf)
                     | (prod_inf & s1_cls_q[2].inf & !any_nan
                        & ((s1_sign_q[0] ^ s1_sign_q[1]) != s1_sign_q[2]));
    end

    // Stage 2 holds while the consumer stalls, keeping outputs stable.
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_invalid_d = s2_invalid_q;
        for (int i = 0; i < 3; i++) begin
            s2_sign_d[i] = s2_sign_q[i];
            s2_exp_d[i]  = s2_exp_q[i];
            s2_sig_d[i]  = s2_sig_q[i];
            s2_cls_d[i]  = s2_cls_q[i];
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_invalid_d = invalid_calc;
                for (int i = 0; i < 3; i++) begin
                    s2_sign_d[i] = s1_sign_q[i];
                    s2_exp_d[i]  = unp_exp[i];
                    s2_sig_d[i]  = unp_sig[i];
                    s2_cls_d[i]  = s1_cls_q[i];
                end
            end
        end
    end

    // A set in the same cycle as a clear takes priority.
    always_comb begin
        sticky_d = sticky_q;
        if (s2_valid_q && bus.out_ready && s2_invalid_q) begin
            sticky_d = 1'b1;
        end else if (bus.flag_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_invalid_q <= 1'b0;
            sticky_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                s1_sign_q[i] <= 1'b0;
                s1_expf_q[i] <= '0;
                s1_frac_q[i] <= '0;
                s1_cls_q[i]  <= '0;
                s2_sign_q[i] <= 1'b0;
                s2_exp_q[i]  <= '0;
                s2_sig_q[i]  <= '0;
                s2_cls_q[i]  <= '0;
            end
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s2_invalid_q <= s2_invalid_d;
            sticky_q     <= sticky_d;
            for (int i = 0; i < 3; i++) begin
                s1_sign_q[i] <= s1_sign_d[i];
                s1_expf_q[i] <= s1_expf_d[i];
                s1_frac_q[i] <= s1_frac_d[i];
                s1_cls_q[i]  <= s1_cls_d[i];
                s2_sign_q[i] <= s2_sign_d[i];
                s2_exp_q[i]  <= s2_exp_d[i];
                s2_sig_q[i]  <= s2_sig_d[i];
                s2_cls_q[i]  <= s2_cls_d[i];
            end
        end
    end

    assign bus.out_valid      = s2_valid_q;
    assign bus.invalid        = s2_invalid_q;
    assign bus.invalid_sticky = sticky_q;

    assign bus.x_sign = s2_sign_q[0];
    assign bus.y_sign = s2_sign_q[1];
    assign bus.z_sign = s2_sign_q[2];
    assign bus.x_exp  = s2_exp_q[0];
    assign bus.y_exp  = s2_exp_q[1];
    assign bus.z_exp  = s2_exp_q[2];
    assign bus.x_sig  = s2_sig_q[0];
    assign bus.y_sig  = s2_sig_q[1];
    assign bus.z_sig  = s2_sig_q[2];
    assign bus.x_zero = s2_cls_q[0].zero;
    assign bus.y_zero = s2_cls_q[1].zero;
    assign bus.z_zero = s2_cls_q[2].zero;
    assign bus.x_inf  = s2_cls_q[0].inf;
    assign bus.y_inf  = s2_cls_q[1].inf;
    assign bus.z_inf  = s2_cls_q[2].inf;
    assign bus.x_qnan = s2_cls_q[0].qnan;
    assign bus.y_qnan = s2_cls_q[1].qnan;
    assign bus.z_qnan = s2_cls_q[2].qnan;
    assign bus.x_snan = s2_cls_q[0].snan;
    assign bus.y_snan = s2_cls_q[1].snan;
    assign bus.z_snan = s2_cls_q[2].snan;
    assign bus.x_sub  = s2_cls_q[0].sub;
    assign bus.y_sub  = s2_cls_q[1].sub;
    assign bus.z_sub  = s2_cls_q[2].sub;

endmodule

// File: tb/tb_fma_operand_unpack.sv
// ---------------------------------------------------------------------------
// tb_fma_operand_unpack
// Self-checking bench for fma_operand_unpack: directed beats with literal
// expectations (half and single precision), backpressure and reset cases,
// then randomized traffic checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fma_operand_unpack;

    localparam int NE = 5;
    localparam int NF = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    fma_operand_unpack_if #(.NE(NE), .NF(NF)) bus ();
    fma_operand_unpack_if #(.NE(8),  .NF(23)) sp_bus ();

    fma_operand_unpack #(.NE(NE), .NF(NF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    fma_operand_unpack #(.NE(8), .NF(23)) dut_sp (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sp_bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit     sign;
        int     exp;
        longint sig;
        bit     zero, inf, qnan, snan, sub;
    } opnd_t;

    typedef struct {
        opnd_t op [3];
        bit    invalid;
    } beat_t;

    // Reference: decode the IEEE encoding directly with integer arithmetic.
    function automatic opnd_t unpack_model(longint raw, int ne, int nf);
        opnd_t  r;
        longint e, f, emax;
        int     b, p, s;
        b    = (1 << (ne - 1)) - 1;
        emax = (longint'(1) << ne) - 1;
        e    = (raw >> nf) & emax;
        f    = raw & ((longint'(1) << nf) - 1);
        r    = '{default: 0};
        r.sign = raw[ne + nf];
        if (e == 0 && f == 0) begin
            r.zero = 1;
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < nf; i++) if (f[i]) p = i;
            s      = nf - p;
            r.sig  = f << s;
            r.exp  = 1 - b - s;
            r.sub  = 1;
        end else begin
            r.exp = int'(e) - b;
            r.sig = f | (longint'(1) << nf);
            if (e == emax) begin
                if (f == 0)          r.inf  = 1;
                else if (f[nf - 1])  r.qnan = 1;
                else                 r.snan = 1;
            end
        end
        return r;
    endfunction

    function automatic beat_t beat_model(longint x, longint y, longint z,
                                         bit mul, bit add, bit negp, bit negz,
                                         int ne, int nf);
        beat_t  bt;
        longint sbit;
        bit     any_snan, any_nan;
        sbit = longint'(1) << (ne + nf);
        if (!mul) y = longint'((1 << (ne - 1)) - 1) << nf;
        if (!add) z = 0;
        if (negp) y = y ^ sbit;
        if (negz) z = z ^ sbit;
        bt.op[0] = unpack_model(x, ne, nf);
        bt.op[1] = unpack_model(y, ne, nf);
        bt.op[2] = unpack_model(z, ne, nf);
        any_snan = bt.op[0].snan | bt.op[1].snan | bt.op[2].snan;
        any_nan  = any_snan | bt.op[0].qnan | bt.op[1].qnan | bt.op[2].qnan;
        bt.invalid = any_snan
                   | (bt.op[0].inf & bt.op[1].zero) | (bt.op[0].zero & bt.op[1].inf)
                   | ((bt.op[0].inf | bt.op[1].inf) & bt.op[2].inf & !any_nan
                      & ((bt.op[0].sign ^ bt.op[1].sign) != bt.op[2].sign));
        return bt;
    endfunction

    function automatic logic [23:0] pack_exp(opnd_t o);
        return {o.sign, 7'(o.exp), 11'(o.sig), o.zero, o.inf, o.qnan, o.snan, o.sub};
    endfunction

    task automatic checkOutput(string name, longint actual, longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: beats are modelled on input handshake and compared in
    // order on output handshake; sticky is tracked from the model's invalid.
    beat_t exp_q [$];
    beat_t mon_beat;
    bit    sticky_model = 0;
    bit    mon_set;

    always @(negedge reset_n) begin
        exp_q.delete();
        sticky_model = 0;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("sticky", longint'(bus.invalid_sticky), longint'(sticky_model));
            mon_set = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    mon_beat = exp_q.pop_front();
                    checkOutput("sb_x", longint'({bus.x_sign, bus.x_exp, bus.x_sig, bus.x_zero,
                                bus.x_inf, bus.x_qnan, bus.x_snan, bus.x_sub}),
                                longint'(pack_exp(mon_beat.op[0])));
                    checkOutput("sb_y", longint'({bus.y_sign, bus.y_exp, bus.y_sig, bus.y_zero,
                                bus.y_inf, bus.y_qnan, bus.y_snan, bus.y_sub}),
                                longint'(pack_exp(mon_beat.op[1])));
                    checkOutput("sb_z", longint'({bus.z_sign, bus.z_exp, bus.z_sig, bus.z_zero,
                                bus.z_inf, bus.z_qnan, bus.z_snan, bus.z_sub}),
                                longint'(pack_exp(mon_beat.op[2])));
                    checkOutput("sb_invalid", longint'(bus.invalid), longint'(mon_beat.invalid));
                    mon_set = mon_beat.invalid;
                end
            end
            if (mon_set)           sticky_model = 1;
            else if (bus.flag_clr) sticky_model = 0;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(beat_model(longint'(bus.x), longint'(bus.y), longint'(bus.z),
                                           bus.mul, bus.add, bus.negp, bus.negz, NE, NF));
            end
        end
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and returns just after the edge that accepted it.
    task automatic applyStimulus(logic [15:0] x, logic [15:0] y, logic [15:0] z,
                                 logic mul, logic add, logic negp, logic negz);
        bit hs;
        bus.x = x; bus.y = y; bus.z = z;
        bus.mul = mul; bus.add = add; bus.negp = negp; bus.negz = negz;
        bus.in_valid = 1'b1;
        hs = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = bus.in_ready;
            stepClock();
        end
        bus.in_valid = 1'b0;
        if (!hs) checkOutput("accept_timeout", 0, 1);
    endtask

    // Single beat with latency check; leaves the beat visible on the outputs.
    task automatic runDirected(logic [15:0] x, logic [15:0] y, logic [15:0] z,
                               logic mul, logic add, logic negp, logic negz);
        applyStimulus(x, y, z, mul, add, negp, negz);
        checkOutput("lat_one_cycle", longint'(bus.out_valid), 0);
        stepClock();
        checkOutput("lat_two_cycle", longint'(bus.out_valid), 1);
    endtask

    function automatic logic [15:0] rand_half();
        logic [4:0] e;
        logic [9:0] f;
        case ($urandom_range(0, 5))
            0:       e = 5'h00;
            1:       e = 5'h1f;
            default: e = 5'($urandom);
        endcase
        f = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom);
        return {1'($urandom), e, f};
    endfunction

    logic [15:0] bp_vals [3];
    logic [10:0] bp_sigs [3];
    int          idx;
    bit          hs;

    initial begin
        bus.in_valid = 0; bus.x = 0; bus.y = 0; bus.z = 0;
        bus.mul = 0; bus.add = 0; bus.negp = 0; bus.negz = 0;
        bus.out_ready = 1; bus.flag_clr = 0;
        sp_bus.in_valid = 0; sp_bus.x = 0; sp_bus.y = 0; sp_bus.z = 0;
        sp_bus.mul = 0; sp_bus.add = 0; sp_bus.negp = 0; sp_bus.negz = 0;
        sp_bus.out_ready = 1; sp_bus.flag_clr = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
        checkOutput("rst_sticky", longint'(bus.invalid_sticky), 0);
        checkOutput("rst_x_exp", longint'(bus.x_exp), 0);
        reset_n = 1;
        stepClock();
        checkOutput("rst_in_ready", longint'(bus.in_ready), 1);

        $display("[TB] directed half-precision beats");
        runDirected(16'h0001, 16'h3C00, 16'h0000, 1, 0, 0, 0);
        checkOutput("sub_x_sub", longint'(bus.x_sub), 1);
        checkOutput("sub_x_exp", longint'($signed(bus.x_exp)), -24);
        checkOutput("sub_x_sig", longint'(bus.x_sig), 'h400);
        checkOutput("sub_y_exp", longint'($signed(bus.y_exp)), 0);
        checkOutput("sub_y_sig", longint'(bus.y_sig), 'h400);
        stepClock();

        runDirected(16'hC000, 16'h1234, 16'h5678, 0, 0, 0, 0);
        checkOutput("subst_y_sig", longint'(bus.y_sig), 'h400);
        checkOutput("subst_y_exp", longint'($signed(bus.y_exp)), 0);
        checkOutput("subst_z_zero", longint'(bus.z_zero), 1);
        checkOutput("subst_x_sign", longint'(bus.x_sign), 1);
        checkOutput("subst_x_exp", longint'($signed(bus.x_exp)), 1);
        stepClock();

        runDirected(16'h3C00, 16'h3C00, 16'h3C00, 1, 1, 0, 1);
        checkOutput("negz_z_sign", longint'(bus.z_sign), 1);
        stepClock();

        runDirected(16'h7C00, 16'h8000, 16'h0000, 1, 0, 0, 0);
        checkOutput("inf_x_zero_invalid", longint'(bus.invalid), 1);
        stepClock();
        checkOutput("inf_x_zero_sticky", longint'(bus.invalid_sticky), 1);

        runDirected(16'h7C00, 16'h3C00, 16'hFC00, 1, 1, 0, 0);
        checkOutput("inf_minus_inf_invalid", longint'(bus.invalid), 1);
        stepClock();

        runDirected(16'h7E00, 16'h0000, 16'h0000, 0, 0, 0, 0);
        checkOutput("qnan_flag", longint'(bus.x_qnan), 1);
        checkOutput("qnan_invalid", longint'(bus.invalid), 0);
        stepClock();

        runDirected(16'h7D00, 16'h0000, 16'h0000, 0, 0, 0, 0);
        checkOutput("snan_flag", longint'(bus.x_snan), 1);
        checkOutput("snan_invalid", longint'(bus.invalid), 1);
        stepClock();

        bus.flag_clr = 1;
        stepClock();
        bus.flag_clr = 0;
        checkOutput("flag_clr_sticky", longint'(bus.invalid_sticky), 0);

        $display("[TB] backpressure");
        bp_vals[0] = 16'h3C00; bp_vals[1] = 16'h4000; bp_vals[2] = 16'h4200;
        bp_sigs[0] = 11'h400;  bp_sigs[1] = 11'h400;  bp_sigs[2] = 11'h600;
        bus.out_ready = 0;
        bus.y = 16'h3C00; bus.z = 0; bus.mul = 1; bus.add = 0; bus.negp = 0; bus.negz = 0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            bus.x = bp_vals[idx];
            bus.in_valid = 1;
            hs = bus.in_ready;
            stepClock();
            if (hs) idx++;
        end
        checkOutput("bp_accepted", longint'(idx), 2);
        checkOutput("bp_in_ready", longint'(bus.in_ready), 0);
        bus.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("bp_no_gap", longint'(bus.out_valid), 1);
            checkOutput("bp_order", longint'(bus.x_sig), longint'(bp_sigs[k]));
            if (idx < 3) begin
                bus.x = bp_vals[idx];
                bus.in_valid = 1;
            end
            hs = bus.in_valid && bus.in_ready;
            stepClock();
            if (hs) idx++;
            bus.in_valid = 0;
        end
        checkOutput("bp_all_taken", longint'(idx), 3);

        $display("[TB] reset with both stages full");
        runDirected(16'h7D00, 16'h0000, 16'h0000, 0, 0, 0, 0);
        stepClock();
        bus.out_ready = 0;
        applyStimulus(16'h3C00, 16'h3C00, 16'h0000, 1, 0, 0, 0);
        applyStimulus(16'h4000, 16'h3C00, 16'h0000, 1, 0, 0, 0);
        checkOutput("full_out_valid", longint'(bus.out_valid), 1);
        checkOutput("full_in_ready", longint'(bus.in_ready), 0);
        checkOutput("full_sticky", longint'(bus.invalid_sticky), 1);
        reset_n = 0;
        #1;
        checkOutput("async_rst_out_valid", longint'(bus.out_valid), 0);
        checkOutput("async_rst_sticky", longint'(bus.invalid_sticky), 0);
        checkOutput("async_rst_x_sig", longint'(bus.x_sig), 0);
        stepClock();
        reset_n = 1;
        bus.out_ready = 1;
        stepClock();
        checkOutput("rel_in_ready", longint'(bus.in_ready), 1);
        checkOutput("rel_out_valid", longint'(bus.out_valid), 0);

        $display("[TB] single precision");
        sp_bus.x = 32'h0000_0001; sp_bus.y = 32'h3F80_0000; sp_bus.z = 0;
        sp_bus.mul = 1; sp_bus.add = 0;
        sp_bus.in_valid = 1;
        stepClock();
        sp_bus.in_valid = 0;
        for (int i = 0; i < 10 && !sp_bus.out_valid; i++) stepClock();
        checkOutput("sp_out_valid", longint'(sp_bus.out_valid), 1);
        checkOutput("sp_x_exp", longint'($signed(sp_bus.x_exp)), -149);
        checkOutput("sp_x_sig", longint'(sp_bus.x_sig), 'h800000);
        checkOutput("sp_x_sub", longint'(sp_bus.x_sub), 1);
        checkOutput("sp_y_exp", longint'($signed(sp_bus.y_exp)), 0);
        stepClock();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flag_clr  = ($urandom_range(0, 9) == 0);
            bus.x = rand_half(); bus.y = rand_half(); bus.z = rand_half();
            bus.mul  = 1'($urandom); bus.add  = 1'($urandom);
            bus.negp = 1'($urandom); bus.negz = 1'($urandom);
            stepClock();
        end
        bus.in_valid = 0;
        bus.flag_clr = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) stepClock();
        checkOutput("drain_empty", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
